fp_rnd_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined IEEE-754 rounding/packing unit with valid/ready

---
 rtl/fp_rnd_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_rnd_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage IEEE-754 rounding and packing unit that sits at the
// tail of the add/mul/div/sqrt datapaths. It takes an unrounded, already
// denormalised significand with guard/round/sticky bits. It returns the packed
// result and the exception flags for that beat, and keeps a sticky
// accumulator of the flags of every delivered beat.
//
// Build option: define FP_RND_FTZ_EN to flush nonzero subnormal results to a
// signed zero (flags UF|NX). Special results are not affected.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    input handshake
//   sig, expo, mant, grs   sign, biased exponent (EW+2 bits), significand
//                          {carry, hidden, fraction}, guard/round/sticky bits
//   rm                     0 rne, 1 rtz, 2 rdn, 3 rup, 4 rmm; 5..7 are invalid
//   snan..zero, diff       special-case tags; diff marks a true subtraction
//   out_valid / out_ready  output handshake
//   result, flags          packed {sign, exp, frac} and {NV,DZ,OF,UF,NX}
//   acc_clr, fflags_acc    clear control and sticky OR of delivered flags
module fp_rnd_pipe #(
    parameter int EW = 11,
    parameter int MW = 52
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           sig,
    input  logic [EW+1:0]  expo,
    input  logic [MW+1:0]  mant,
    input  logic [2:0]     grs,
    input  logic [2:0]     rm,
    input  logic           snan,
    input  logic           qnan,
    input  logic           dbz,
    input  logic           inf,
    input  logic           zero,
    input  logic           diff,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] result,
    output logic [4:0]     flags,
    input  logic           acc_clr,
    output logic [4:0]     fflags_acc
);

    localparam int STAGES = 2;

    localparam logic [EW+MW:0] QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic [EW-1:0]  EXP_INF  = {EW{1'b1}};
    localparam logic [EW-1:0]  EXP_MAXF = {{(EW-1){1'b1}}, 1'b0};
    // Largest exponent that is still finite, widened for the compare.
    localparam logic [EW+2:0]  EMAX     = {3'b000, EXP_MAXF};

    // State carried from the rounding stage to the packing stage. Special
    // cases are resolved in stage 1, so stage 2 only has to select them.
    typedef struct packed {
        logic           sgn;
        logic [EW+1:0]  expo;
        logic [MW+1:0]  mant;
        logic           nx;
        logic           uf;
        logic [2:0]     rm;
        logic           spec;
        logic [EW+MW:0] spec_res;
        logic [4:0]     spec_flags;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    logic            en1, en2;
    s1_t             s1_n, s1_q;
    logic            nx0, inc;

    logic [EW+2:0]   e2;
    logic [MW-1:0]   m2;
    logic            ovf, to_inf;
    logic [EW+MW:0]  res_n;
    logic [4:0]      flags_n;

    // A stage can advance when it is empty or the stage after it is moving.
    assign en2       = ~vld_pipe[2] | out_ready;
    assign en1       = ~vld_pipe[1] | en2;
    assign in_ready  = en1;
    assign out_valid = vld_pipe[2];

    // Stage 1: round decision and special-case resolution.
    always_comb begin
        nx0 = |grs;
        case (rm)
            3'd0:    inc = grs[2] & (grs[1] | grs[0] | mant[0]);
            3'd2:    inc = sig & nx0;
            3'd3:    inc = ~sig & nx0;
            3'd4:    inc = grs[2];
            default: inc = 1'b0;
        endcase

        s1_n      = '0;
        s1_n.sgn  = sig;
        s1_n.expo = expo;
        s1_n.mant = mant + {{(MW+1){1'b0}}, inc};
        s1_n.nx   = nx0;
        // Tininess is detected before rounding.
        s1_n.uf   = nx0 & (expo == '0);
        s1_n.rm   = rm;

        if (rm > 3'd4) begin
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = QNAN;
            s1_n.spec_flags = 5'b10000;
        end else if (snan) begin
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = QNAN;
            s1_n.spec_flags = 5'b10000;
        end else if (qnan) begin
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = QNAN;
        end else if (dbz) begin
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = {sig, EXP_INF, {MW{1'b0}}};
            s1_n.spec_flags = 5'b01000;
        end else if (inf) begin
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = {sig, EXP_INF, {MW{1'b0}}};
        end else if (zero) begin
            // An exact zero from x - x is -0 only when rounding down.
            s1_n.spec       = 1'b1;
            s1_n.spec_res   = {sig | ((rm == 3'd2) & diff), {(EW+MW){1'b0}}};
        end
    end

    // Stage 2: renormalise, detect overflow, pack.
    always_comb begin
        e2 = {1'b0, s1_q.expo};
        m2 = s1_q.mant[MW-1:0];
        if (s1_q.mant[MW+1]) begin
            m2 = s1_q.mant[MW:1];
            e2 = e2 + (EW+3)'(1);
        end else if ((s1_q.expo == '0) && s1_q.mant[MW]) begin
            // Rounding carried a subnormal into the smallest normal binade.
            e2 = (EW+3)'(1);
        end

        ovf    = e2 > EMAX;
        to_inf = (s1_q.rm == 3'd0) || (s1_q.rm == 3'd4) ||
                 ((s1_q.rm == 3'd3) && !s1_q.sgn) ||
                 ((s1_q.rm == 3'd2) && s1_q.sgn);

        // The subnormal case packs the same way since e2 is already zero.
        res_n   = {s1_q.sgn, e2[EW-1:0], m2};
        flags_n = {3'b000, s1_q.uf, s1_q.nx};

        if (s1_q.spec) begin
            res_n   = s1_q.spec_res;
            flags_n = s1_q.spec_flags;
        end else if (ovf) begin
            res_n   = to_inf ? {s1_q.sgn, EXP_INF, {MW{1'b0}}}
                             : {s1_q.sgn, EXP_MAXF, {MW{1'b1}}};
            flags_n = 5'b00101;
        end
`ifdef FP_RND_FTZ_EN
        else if ((e2 == '0) && (m2 != '0)) begin
            res_n   = {s1_q.sgn, {(EW+MW){1'b0}}};
            flags_n = 5'b00011;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            result     <= '0;
            flags      <= '0;
            fflags_acc <= '0;
        end else begin
            if (en1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= s1_n;
            end
            if (en2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    result <= res_n;
                    flags  <= flags_n;
                end
            end
            // A clear on a delivering cycle keeps that beat's flags.
            if (out_valid && out_ready)
                fflags_acc <= acc_clr ? flags : (fflags_acc | flags);
            else if (acc_clr)
                fflags_acc <= '0;
        end
    end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
module tb_fp_rnd_pipe;
    localparam int EW = 8;
    localparam int MW = 23;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [2:0]  grs, rm;
    logic        snan, qnan, dbz, inf, zero, diff;
    logic        out_valid, out_ready, acc_clr;
    logic [31:0] result;
    logic [4:0]  flags, fflags_acc;

    always #5 clock = ~clock;

    fp_rnd_pipe #(.EW(EW), .MW(MW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sig(sig), .expo(expo), .mant(mant), .grs(grs), .rm(rm),
        .snan(snan), .qnan(qnan), .dbz(dbz), .inf(inf), .zero(zero), .diff(diff),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
        .acc_clr(acc_clr), .fflags_acc(fflags_acc)
    );

    typedef struct {
        logic        sg;
        logic [9:0]  ex;
        logic [24:0] mt;
        logic [2:0]  gr;
        logic [2:0]  md;
        logic        sn, qn, dz, nf, zr, df;
    } beat_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    beat_t      stim_q[$];
    exp_t       stim_e[$];
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [4:0] acc_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic beat_t mk(input bit sg, input int ex, input int mt, input int gr, input int md);
        beat_t b;
        b.sg = sg; b.ex = 10'(ex); b.mt = 25'(mt); b.gr = 3'(gr); b.md = 3'(md);
        b.sn = 0; b.qn = 0; b.dz = 0; b.nf = 0; b.zr = 0; b.df = 0;
        return b;
    endfunction

    // Reference: value-level rounding of the significand integer, then IEEE
    // range handling. Written from the rounding rules, not the pipeline.
    function automatic exp_t model(input beat_t b);
        exp_t   r;
        longint m;
        int     e;
        bit     g, rr, s, nx, up, uf, to_inf;
        g = b.gr[2]; rr = b.gr[1]; s = b.gr[0];
        nx = g | rr | s;
        if (b.md > 3'd4)  begin r.res = 32'h7FC00000; r.fl = 5'b10000; return r; end
        if (b.sn)         begin r.res = 32'h7FC00000; r.fl = 5'b10000; return r; end
        if (b.qn)         begin r.res = 32'h7FC00000; r.fl = 5'b00000; return r; end
        if (b.dz)         begin r.res = {b.sg, 8'hFF, 23'h0}; r.fl = 5'b01000; return r; end
        if (b.nf)         begin r.res = {b.sg, 8'hFF, 23'h0}; r.fl = 5'b00000; return r; end
        if (b.zr) begin
            r.res = {b.sg | (b.md == 3'd2 && b.df), 31'h0}; r.fl = 5'b00000; return r;
        end
        case (b.md)
            3'd0:    up = (g && (rr || s)) || (g && !rr && !s && b.mt[0]);
            3'd2:    up = b.sg && nx;
            3'd3:    up = !b.sg && nx;
            3'd4:    up = g;
            default: up = 0;
        endcase
        m  = longint'(b.mt) + (up ? 64'd1 : 64'd0);
        e  = int'(b.ex);
        uf = (b.ex == 0) && nx;
        if (m >= 64'h1000000) begin
            m = m / 2;
            e = e + 1;
        end else if (e == 0 && m >= 64'h800000) begin
            e = 1;
        end
        if (e > 254) begin
            to_inf = (b.md == 0) || (b.md == 4) || (b.md == 3 && !b.sg) || (b.md == 2 && b.sg);
            r.res  = to_inf ? {b.sg, 8'hFF, 23'h0} : {b.sg, 8'hFE, 23'h7FFFFF};
            r.fl   = 5'b00101;
            return r;
        end
        r.res = {b.sg, 8'(e), m[22:0]};
        r.fl  = {3'b000, uf, nx};
`ifdef FP_RND_FTZ_EN
        if (e == 0 && m[22:0] != 0) begin
            r.res = {b.sg, 31'h0};
            r.fl  = 5'b00011;
        end
`endif
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    k;
        b = mk(1'($urandom), 0, 0, 0, 0);
        k = $urandom_range(0, 9);
        if (k < 2)       b.ex = 10'd0;
        else if (k == 2) b.ex = 10'($urandom_range(253, 256));
        else             b.ex = 10'($urandom_range(1, 254));
        if (b.ex == 0)                      b.mt = {2'b00, 23'($urandom)};
        else if ($urandom_range(0, 7) == 0) b.mt = {2'b10, 23'($urandom)};
        else                                b.mt = {2'b01, 23'($urandom)};
        if ($urandom_range(0, 5) == 0) b.mt[22:0] = '1;
        b.gr = 3'($urandom);
        b.md = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        b.sn = ($urandom_range(0, 19) == 0);
        b.qn = ($urandom_range(0, 19) == 0);
        b.dz = ($urandom_range(0, 19) == 0);
        b.nf = ($urandom_range(0, 19) == 0);
        b.zr = ($urandom_range(0, 15) == 0);
        b.df = 1'($urandom);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sig = b.sg; expo = b.ex; mant = b.mt; grs = b.gr; rm = b.md;
        snan = b.sn; qnan = b.qn; dbz = b.dz; inf = b.nf; zero = b.zr; diff = b.df;
    endtask

    task automatic add_exp(input beat_t b, input logic [31:0] res, input logic [4:0] fl);
        exp_t e;
        e.res = res; e.fl = fl;
        stim_q.push_back(b);
        stim_e.push_back(e);
    endtask

    task automatic add_model(input beat_t b);
        stim_q.push_back(b);
        stim_e.push_back(model(b));
    endtask

    // One clock of stimulus plus scoreboard bookkeeping for the next edge.
    // clr_mode: 0 none, 1 always, 2 on the final delivered beat, 3 random.
    task automatic tick(input bit send, input bit ordy, input int clr_mode, input int exp_ir);
        exp_t e;
        @(negedge clock);
        in_valid = send && (stim_q.size() != 0);
        if (in_valid) drive(stim_q[0]);
        else          drive(rand_beat());
        out_ready = ordy;
        acc_clr   = 1'b0;
        #1;
        case (clr_mode)
            1:       acc_clr = 1'b1;
            2:       acc_clr = out_valid && (exp_q.size() == 1) && (stim_q.size() == 0);
            3:       acc_clr = ($urandom_range(0, 19) == 0);
            default: acc_clr = 1'b0;
        endcase
        #1;
        chk("fflags_acc", 32'(fflags_acc), 32'(acc_m));
        if (exp_ir >= 0) chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("flags", 32'(flags), 32'(e.fl));
                acc_m = acc_clr ? e.fl : (acc_m | e.fl);
            end
        end else if (acc_clr) begin
            acc_m = '0;
        end
        if (in_valid && in_ready) begin
            void'(stim_q.pop_front());
            exp_q.push_back(stim_e.pop_front());
        end
    endtask

    task automatic drain(input int budget, input int clr_mode);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick(1'b1, 1'b1, clr_mode, -1);
            n++;
        end
        chk("drain_pending", 32'(stim_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        beat_t b;
        int    n;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
        drive(mk(0, 0, 0, 0, 0));
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_acc", 32'(fflags_acc), 32'd0);

        // Directed rounding, overflow, subnormal and special cases.
        add_exp(mk(0, 127, 25'h0800001, 3'b100, 0), 32'h3F800002, 5'b00001);
        add_exp(mk(0, 127, 25'h0FFFFFF, 3'b110, 0), 32'h40000000, 5'b00001);
        add_exp(mk(0, 254, 25'h0FFFFFF, 3'b100, 0), 32'h7F800000, 5'b00101);
        add_exp(mk(0, 255, 25'h0800000, 3'b000, 1), 32'h7F7FFFFF, 5'b00101);
        add_exp(mk(1, 254, 25'h0FFFFFF, 3'b100, 2), 32'hFF800000, 5'b00101);
        add_exp(mk(1, 255, 25'h0800000, 3'b001, 3), 32'hFF7FFFFF, 5'b00101);
`ifdef FP_RND_FTZ_EN
        add_exp(mk(0, 0, 25'h0000001, 3'b010, 3), 32'h00000000, 5'b00011);
`else
        add_exp(mk(0, 0, 25'h0000001, 3'b010, 3), 32'h00000002, 5'b00011);
`endif
        add_exp(mk(0, 0, 25'h07FFFFF, 3'b100, 0), 32'h00800000, 5'b00011);
        b = mk(0, 0, 0, 0, 2); b.zr = 1; b.df = 1;
        add_exp(b, 32'h80000000, 5'b00000);
        b = mk(0, 0, 0, 0, 0); b.sn = 1;
        add_exp(b, 32'h7FC00000, 5'b10000);
        add_exp(mk(0, 127, 25'h0800000, 3'b000, 5), 32'h7FC00000, 5'b10000);
        b = mk(1, 0, 0, 0, 0); b.dz = 1;
        add_exp(b, 32'hFF800000, 5'b01000);
        drain(100, 0);

        // Clear with no beat delivered.
        tick(1'b0, 1'b1, 1, -1);
        tick(1'b0, 1'b1, 0, -1);
        chk("acc_clr_idle", 32'(fflags_acc), 32'd0);

        // Four back-to-back beats into a stalled output.
        b = mk(0, 0, 0, 0, 2); b.zr = 1; b.df = 1;
        add_exp(b, 32'h80000000, 5'b00000);
        b = mk(0, 0, 0, 0, 0); b.sn = 1;
        add_exp(b, 32'h7FC00000, 5'b10000);
        add_exp(mk(0, 254, 25'h0FFFFFF, 3'b100, 0), 32'h7F800000, 5'b00101);
        add_exp(mk(0, 127, 25'h0800001, 3'b100, 0), 32'h3F800002, 5'b00001);
        tick(1'b1, 1'b0, 0, 1);
        tick(1'b1, 1'b0, 0, 1);
        tick(1'b1, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 0, 0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_result", result, 32'h80000000);
        drain(40, 2);
        tick(1'b0, 1'b1, 0, -1);
        chk("acc_clr_last_beat", 32'(fflags_acc), 32'h01);

        // Randomised traffic with random gaps, backpressure and clears.
        for (int i = 0; i < 400; i++) add_model(rand_beat());
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, 3, -1);
            n++;
        end
        chk("random_pending", 32'(stim_q.size() + exp_q.size()), 32'd0);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) add_model(rand_beat());
        tick(1'b1, 1'b0, 0, -1);
        tick(1'b1, 1'b0, 0, -1);
        tick(1'b1, 1'b0, 0, -1);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_acc", 32'(fflags_acc), 32'd0);
        reset = 1'b0;
        stim_q.delete(); stim_e.delete(); exp_q.delete();
        acc_m = '0;
        tick(1'b0, 1'b1, 0, -1);
        chk("after_reset_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
